id_stage: RTL

//  ARM instruction-decode stage. Sits between the IF/ID register and the ID/EX pipeline register.

---
 rtl/id_stage_if.sv | 43 ++++
 rtl/id_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/id_stage_if.sv
// Bundle of the decode stage's bus signals: the IF/ID inputs, the WB write
// port and the decoded control/operand outputs heading to ID/EX.
// The slave modport is the decode stage; the master modport is the surrounding pipeline.
interface id_stage_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       instruction;
  logic [31:0]       pc_in;
  logic [3:0]        status;
  logic              hazard;
  logic              wb_wb_en;
  logic [3:0]        wb_dest;
  logic [DATA_W-1:0] wb_value;

  logic              wb_en;
  logic              mem_read;
  logic              mem_write;
  logic              b;
  logic              s;
  logic              imm;
  logic [3:0]        alu_command;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm;
  logic [3:0]        dest;
  logic [3:0]        src1;
  logic [3:0]        src2;
  logic              two_src;
  logic [31:0]       pc_out;

  modport master (
    output instruction, pc_in, status, hazard, wb_wb_en, wb_dest, wb_value,
    input  wb_en, mem_read, mem_write, b, s, imm, alu_command, val_rn, val_rm,
           shift_operand, signed_imm, dest, src1, src2, two_src, pc_out
  );

  modport slave (
    input  instruction, pc_in, status, hazard, wb_wb_en, wb_dest, wb_value,
    output wb_en, mem_read, mem_write, b, s, imm, alu_command, val_rn, val_rm,
           shift_operand, signed_imm, dest, src1, src2, two_src, pc_out
  );
endinterface

// File: rtl/id_stage.sv
// ARM instruction-decode stage: 16-entry register file written by WB,
// combinational field/control decode, condition-code evaluation and squash.
// Optional feature: define ID_REGFILE_BYPASS_EN to forward a same-cycle WB
// write to the read ports; otherwise reads return only the stored value.
module id_stage #(
  parameter int DATA_W    = 32,
  parameter int RST_INDEX = 1
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  logic [DATA_W-1:0] regs [16];

  logic [3:0] cond;
  logic [1:0] mode;
  logic       i_bit;
  logic [3:0] op;
  logic       s_bit;
  logic [3:0] rn;
  logic [3:0] rd;
  logic [3:0] src2;

  logic       dec_wb_en;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_b;
  logic       dec_s;
  logic [3:0] dec_alu;

  logic       n_flag, z_flag, c_flag, v_flag;
  logic       cond_pass;
  logic       squash;

  logic [DATA_W-1:0] rd_rn;
  logic [DATA_W-1:0] rd_rm;

  assign cond  = bus.instruction[31:28];
  assign mode  = bus.instruction[27:26];
  assign i_bit = bus.instruction[25];
  assign op    = bus.instruction[24:21];
  assign s_bit = bus.instruction[20];
  assign rn    = bus.instruction[19:16];
  assign rd    = bus.instruction[15:12];

  // Register file: async reset to index or zero, write from WB on the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= (RST_INDEX != 0) ? DATA_W'(i) : '0;
      end
    end else if (bus.wb_wb_en) begin
      regs[bus.wb_dest] <= bus.wb_value;
    end
  end

  // Decode mode/opcode into raw (unsquashed) control and ALU command.
  always_comb begin
    dec_wb_en     = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_b         = 1'b0;
    dec_s         = 1'b0;
    dec_alu       = 4'b0000;
    case (mode)
      2'b00: begin
        dec_wb_en = 1'b1;
        dec_s     = s_bit;
        case (op)
          4'b1101: dec_alu = 4'b0001;
          4'b1111: dec_alu = 4'b1001;
          4'b0100: dec_alu = 4'b0010;
          4'b0101: dec_alu = 4'b0011;
          4'b0010: dec_alu = 4'b0100;
          4'b0110: dec_alu = 4'b0101;
          4'b0000: dec_alu = 4'b0110;
          4'b1100: dec_alu = 4'b0111;
          4'b0001: dec_alu = 4'b1000;
          4'b1010: begin dec_alu = 4'b0100; dec_wb_en = 1'b0; end
          4'b1000: begin dec_alu = 4'b0110; dec_wb_en = 1'b0; end
          default: begin dec_wb_en = 1'b0; dec_s = 1'b0; end
        endcase
      end
      2'b01: begin
        dec_alu = 4'b0010;
        if (s_bit) begin
          dec_mem_read = 1'b1;
          dec_wb_en    = 1'b1;
        end else begin
          dec_mem_write = 1'b1;
        end
      end
      2'b10: begin
        dec_b = 1'b1;
      end
      default: ;
    endcase
  end

  assign n_flag = bus.status[3];
  assign z_flag = bus.status[2];
  assign c_flag = bus.status[1];
  assign v_flag = bus.status[0];

  // Evaluate the condition field against NZCV.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = z_flag;
      4'b0001: cond_pass = ~z_flag;
      4'b0010: cond_pass = c_flag;
      4'b0011: cond_pass = ~c_flag;
      4'b0100: cond_pass = n_flag;
      4'b0101: cond_pass = ~n_flag;
      4'b0110: cond_pass = v_flag;
      4'b0111: cond_pass = ~v_flag;
      4'b1000: cond_pass = c_flag & ~z_flag;
      4'b1001: cond_pass = ~c_flag | z_flag;
      4'b1010: cond_pass = (n_flag == v_flag);
      4'b1011: cond_pass = (n_flag != v_flag);
      4'b1100: cond_pass = ~z_flag & (n_flag == v_flag);
      4'b1101: cond_pass = z_flag | (n_flag != v_flag);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Stores read Rd as the second operand so its data reaches memory.
  assign src2   = dec_mem_write ? rd : bus.instruction[3:0];
  assign squash = ~cond_pass | bus.hazard | rst;

  // Register read ports, optionally forwarding a same-cycle WB write.
  always_comb begin
    rd_rn = regs[rn];
    rd_rm = regs[src2];
`ifdef ID_REGFILE_BYPASS_EN
    if (bus.wb_wb_en && (bus.wb_dest == rn))   rd_rn = bus.wb_value;
    if (bus.wb_wb_en && (bus.wb_dest == src2)) rd_rm = bus.wb_value;
`endif
  end

  assign bus.wb_en         = dec_wb_en     & ~squash;
  assign bus.mem_read      = dec_mem_read  & ~squash;
  assign bus.mem_write     = dec_mem_write & ~squash;
  assign bus.b             = dec_b         & ~squash;
  assign bus.s             = dec_s         & ~squash;
  assign bus.imm           = i_bit;
  assign bus.alu_command   = dec_alu;
  assign bus.val_rn        = rd_rn;
  assign bus.val_rm        = rd_rm;
  assign bus.shift_operand = bus.instruction[11:0];
  assign bus.signed_imm    = bus.instruction[23:0];
  assign bus.dest          = rd;
  assign bus.src1          = rn;
  assign bus.src2          = src2;
  assign bus.two_src       = ((mode == 2'b00) & ~i_bit) | dec_mem_write;
  assign bus.pc_out        = bus.pc_in;

endmodule
